ball_engine: RTL

Ball motion and ball-pixel generator for Breakout. It sits directly downstream of the VGA sync stage and consumes its `xIndex`/`yIndex`/`displayEnable` scan outputs. Once per frame it advances the ball and resolves wall, paddle and miss events. On every clock it reports whether the current scan pixel lies inside the ball, for the colour mux.

---
 rtl/ball_engine.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ball_engine.sv
// Breakout ball engine: advances the ball once per frame and flags scan pixels inside it.
// State table (state | meaning):
//   IDLE   | ball parked on the paddle, waiting for a serve on the frame tick
//   MOVING | ball in flight, wall/paddle/miss resolved every frame tick
//   MISS   | ball lost, hidden for MISS_FRAMES ticks before returning to IDLE
module ball_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int PADDLE_Y    = 456,
  parameter int PADDLE_W    = 64,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [9:0] xIndex,
  input  logic [9:0] yIndex,
  input  logic       displayEnable,
  input  logic [9:0] paddleX,
  input  logic       launch,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic       ballPixel,
  output logic       missPulse,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVING = 2'd1, MISS = 2'd2} state_t;

  localparam int MC_W = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

  localparam logic [10:0] W11       = 11'(SCREEN_W);
  localparam logic [10:0] H11       = 11'(SCREEN_H);
  localparam logic [10:0] BS11      = 11'(BALL_SIZE);
  localparam logic [10:0] SP11      = 11'(SPEED);
  localparam logic [10:0] PY11      = 11'(PADDLE_Y);
  localparam logic [10:0] PW11      = 11'(PADDLE_W);
  localparam logic [10:0] PAD_MAX   = 11'(SCREEN_W - PADDLE_W);
  localparam logic [10:0] SERVE_OFS = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  X_MAX     = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0]  X_RESET   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_REST    = 10'(PADDLE_Y - BALL_SIZE);
  localparam logic [9:0]  SP10      = 10'(SPEED);
  localparam logic [9:0]  Y_TICK    = 10'(SCREEN_H);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MISS_FRAMES - 1);

  state_t          stateQ;
  logic            dirX, dirY;
  logic [9:0]      prevY;
  logic [MC_W-1:0] missCount;

  logic        frameTick;
  logic [10:0] x11, y11, yBot, padC, idleSum, scanX, scanY;
  logic [9:0]  idleX, nextX, nextY;
  logic        nextDirX, nextDirY, paddleHit, missHit, inBall;

  assign frameTick = (yIndex == Y_TICK) && (prevY != Y_TICK);
  assign state     = stateQ;

  assign x11     = {1'b0, ballX};
  assign y11     = {1'b0, ballY};
  assign yBot    = y11 + BS11;
  assign padC    = ({1'b0, paddleX} > PAD_MAX) ? PAD_MAX : {1'b0, paddleX};
  assign idleSum = padC + SERVE_OFS;
  assign idleX   = (idleSum > {1'b0, X_MAX}) ? X_MAX : idleSum[9:0];

  assign paddleHit = dirY && (yBot <= PY11) && (yBot + SP11 >= PY11) &&
                     (x11 + BS11 > padC) && (x11 < padC + PW11);
  assign missHit   = dirY && !paddleHit && (yBot + SP11 >= H11);

  always_comb begin
    nextX    = ballX;
    nextDirX = dirX;
    if (dirX) begin
      if (x11 + BS11 + SP11 >= W11) begin
        nextX    = X_MAX;
        nextDirX = 1'b0;
      end else begin
        nextX = ballX + SP10;
      end
    end else if (x11 <= SP11) begin
      nextX    = '0;
      nextDirX = 1'b1;
    end else begin
      nextX = ballX - SP10;
    end
  end

  always_comb begin
    nextY    = ballY;
    nextDirY = dirY;
    if (!dirY) begin
      if (y11 <= SP11) begin
        nextY    = '0;
        nextDirY = 1'b1;
      end else begin
        nextY = ballY - SP10;
      end
    end else if (paddleHit) begin
      nextY    = Y_REST;
      nextDirY = 1'b0;
    end else begin
      nextY = ballY + SP10;
    end
  end

  assign scanX  = {1'b0, xIndex};
  assign scanY  = {1'b0, yIndex};
  assign inBall = (scanX >= x11) && (scanX < x11 + BS11) &&
                  (scanY >= y11) && (scanY < y11 + BS11);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      stateQ    <= IDLE;
      ballX     <= X_RESET;
      ballY     <= Y_REST;
      dirX      <= 1'b1;
      dirY      <= 1'b0;
      ballPixel <= 1'b0;
      missPulse <= 1'b0;
      missCount <= '0;
      prevY     <= '0;
    end else begin
      prevY     <= yIndex;
      missPulse <= 1'b0;
      ballPixel <= displayEnable && (stateQ != MISS) && inBall;
      if (frameTick) begin
        case (stateQ)
          IDLE: begin
            ballX <= idleX;
            ballY <= Y_REST;
            if (launch) begin
              stateQ <= MOVING;
              dirX   <= 1'b1;
              dirY   <= 1'b0;
            end
          end
          MOVING: begin
            // a miss freezes the ball where it was lost
            if (missHit) begin
              stateQ    <= MISS;
              missPulse <= 1'b1;
              missCount <= '0;
            end else begin
              ballX <= nextX;
              ballY <= nextY;
              dirX  <= nextDirX;
              dirY  <= nextDirY;
            end
          end
          MISS: begin
            missCount <= missCount + 1'b1;
            if (missCount == MC_LAST) begin
              stateQ <= IDLE;
              ballY  <= Y_REST;
              dirX   <= 1'b1;
              dirY   <= 1'b0;
            end
          end
          default: stateQ <= IDLE;
        endcase
      end
    end
  end

endmodule
